// File: rtl/vga_pkg.sv
// Shared raster constants for the 800x600 @ 60 Hz video chain and a small window helper.
// The menu, game and draw stages import this alongside the timing generator.
package vga_pkg;

  localparam int unsigned COUNT_W = 11;

  localparam int unsigned DEF_H_ACTIVE     = 800;
  localparam int unsigned DEF_H_SYNC_START = 840;
  localparam int unsigned DEF_H_SYNC_END   = 968;
  localparam int unsigned DEF_H_TOTAL      = 1056;

  localparam int unsigned DEF_V_ACTIVE     = 600;
  localparam int unsigned DEF_V_SYNC_START = 601;
  localparam int unsigned DEF_V_SYNC_END   = 605;
  localparam int unsigned DEF_V_TOTAL      = 628;

  typedef logic [COUNT_W-1:0] count_t;

  // Compared at 32 bits so an upper bound of 2048 still works with 11-bit counts.
  function automatic logic in_window(count_t c, int unsigned lo, int unsigned hi);
    int unsigned v;
    v = 32'(c);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping counter plus registered sync and blank flags.
// Flags are derived from the next-state count so they stay aligned with count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned SYNC_END   = DEF_H_SYNC_END,
  parameter int unsigned TOTAL      = DEF_H_TOTAL,
  parameter logic        POL        = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc_en,
  output logic [COUNT_W-1:0] count,
  output logic               sync,
  output logic               blnk,
  output logic               wrap
);

  if (!(ACTIVE < SYNC_START && SYNC_START < SYNC_END &&
        SYNC_END <= TOTAL && TOTAL <= 2048)) begin : g_bad_timing
    $error("vga_axis_counter: timing parameters out of order or exceed 2048");
  end

  localparam count_t LAST = count_t'(TOTAL - 1);

  count_t count_q, count_d;
  logic   sync_q, sync_d;
  logic   blnk_q, blnk_d;

  // >= rather than == keeps the counter inside range from any power-up value.
  assign wrap = inc_en && (count_q >= LAST);

  always_comb begin
    count_d = count_q;
    if (wrap) begin
      count_d = '0;
    end else if (inc_en) begin
      count_d = count_q + count_t'(1);
    end
    sync_d = in_window(count_d, SYNC_START, SYNC_END) ? POL : ~POL;
    blnk_d = (32'(count_d) >= ACTIVE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
      sync_q  <= ~POL;
      blnk_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      sync_q  <= sync_d;
      blnk_q  <= blnk_d;
    end
  end

  assign count = count_q;
  assign sync  = sync_q;
  assign blnk  = blnk_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: registered hcount/vcount, syncs, blanks and a
// one-cycle frame_start pulse at pixel (0,0) of every frame after the first.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
  parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
  parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
  parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
  parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
  parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
  parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END,
  parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
  parameter logic        HS_POL       = 1'b1,
  parameter logic        VS_POL       = 1'b1
) (
  input  logic        pclk,
  input  logic        rst,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        hsync,
  output logic        vsync,
  output logic        hblnk,
  output logic        vblnk,
  output logic        frame_start
);

  logic h_wrap;
  logic v_wrap;
  logic frame_start_q, frame_start_d;

  vga_axis_counter #(
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_SYNC_START),
    .SYNC_END   (H_SYNC_END),
    .TOTAL      (H_TOTAL),
    .POL        (HS_POL)
  ) u_h (
    .clk    (pclk),
    .rst    (rst),
    .inc_en (1'b1),
    .count  (hcount),
    .sync   (hsync),
    .blnk   (hblnk),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_SYNC_START),
    .SYNC_END   (V_SYNC_END),
    .TOTAL      (V_TOTAL),
    .POL        (VS_POL)
  ) u_v (
    .clk    (pclk),
    .rst    (rst),
    .inc_en (h_wrap),
    .count  (vcount),
    .sync   (vsync),
    .blnk   (vblnk),
    .wrap   (v_wrap)
  );

  // A vertical wrap only happens on a horizontal wrap, so next state is (0,0).
  assign frame_start_d = v_wrap;

  always_ff @(posedge pclk) begin
    if (!rst) begin
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboarded bench for vga_timing_gen on a shrunken raster, with one
// positive-polarity and one negative-polarity instance sharing clock and reset.
module tb_vga_timing_gen;

  localparam int HA = 8, HSS = 10, HSE = 13, HT = 16;
  localparam int VA = 6, VSS = 7,  VSE = 9,  VT = 11;
  localparam int FRAME = HT * VT;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
  } exp_t;

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hc_p, vc_p, hc_n, vc_n;
  logic        hs_p, vs_p, hb_p, vb_p, fs_p;
  logic        hs_n, vs_n, hb_n, vb_n, fs_n;

  exp_t sb[$];
  int   pulses[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mh = 0, mv = 0;
  logic mfs = 1'b0;
  int   hs_cnt = 0, vs_cnt = 0, hb_cnt = 0, vb_cnt = 0, hsn_cnt = 0, vsn_cnt = 0;
  bit   found;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .HS_POL(1'b1), .VS_POL(1'b1)
  ) dut_p (
    .pclk(pclk), .rst(rst), .hcount(hc_p), .vcount(vc_p), .hsync(hs_p),
    .vsync(vs_p), .hblnk(hb_p), .vblnk(vb_p), .frame_start(fs_p)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
    .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut_n (
    .pclk(pclk), .rst(rst), .hcount(hc_n), .vcount(vc_n), .hsync(hs_n),
    .vsync(vs_n), .hblnk(hb_n), .vblnk(vb_n), .frame_start(fs_n)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive rst for one edge, then push the raster state expected after that edge.
  task automatic cyc(input logic r);
    exp_t e;
    rst = r;
    @(posedge pclk);
    #1;
    if (!r) begin
      mh = 0; mv = 0; mfs = 1'b0;
    end else begin
      if (mh == HT - 1) begin
        mh = 0;
        mv = (mv == VT - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
      mfs = (mh == 0) && (mv == 0);
    end
    e.h  = 11'(mh);
    e.v  = 11'(mv);
    e.hs = (mh >= HSS) && (mh < HSE);
    e.vs = (mv >= VSS) && (mv < VSE);
    e.hb = (mh >= HA);
    e.vb = (mv >= VA);
    e.fs = mfs;
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge pclk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("p.hcount", int'(hc_p), int'(e.h));
        chk("p.vcount", int'(vc_p), int'(e.v));
        chk("p.hsync",  int'(hs_p), int'(e.hs));
        chk("p.vsync",  int'(vs_p), int'(e.vs));
        chk("p.hblnk",  int'(hb_p), int'(e.hb));
        chk("p.vblnk",  int'(vb_p), int'(e.vb));
        chk("p.frame_start", int'(fs_p), int'(e.fs));
        chk("n.hcount", int'(hc_n), int'(e.h));
        chk("n.vcount", int'(vc_n), int'(e.v));
        chk("n.hsync",  int'(hs_n), int'(!e.hs));
        chk("n.vsync",  int'(vs_n), int'(!e.vs));
        chk("n.frame_start", int'(fs_n), int'(e.fs));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b0;
    repeat (5) cyc(1'b0);

    for (int c = 1; c <= 3; c++) begin
      cyc(1'b1);
      chk("release hcount", int'(hc_p), c);
    end

    // Edge c after release leaves the raster at (c mod 16, (c/16) mod 11).
    for (int c = 4; c <= 3 * FRAME + 12; c++) begin
      cyc(1'b1);
      if (fs_p) pulses.push_back(c);
      if (c >= FRAME && c < 2 * FRAME) begin
        hs_cnt  += int'(hs_p);
        vs_cnt  += int'(vs_p);
        hb_cnt  += int'(hb_p);
        vb_cnt  += int'(vb_p);
        hsn_cnt += int'(!hs_n);
        vsn_cnt += int'(!vs_n);
      end
    end
    chk("frame_start count", pulses.size(), 3);
    if (pulses.size() > 0) chk("first frame_start cycle", pulses[0], 176);
    for (int i = 1; i < pulses.size(); i++)
      chk("frame_start spacing", pulses[i] - pulses[i-1], 176);
    chk("hsync cycles/frame", hs_cnt, 33);
    chk("vsync cycles/frame", vs_cnt, 32);
    chk("hblnk cycles/frame", hb_cnt, 88);
    chk("vblnk cycles/frame", vb_cnt, 80);
    chk("n.hsync low cycles/frame", hsn_cnt, 33);
    chk("n.vsync low cycles/frame", vsn_cnt, 32);

    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      if (mh == 5 && mv == 3) found = 1'b1;
      else cyc(1'b1);
    end
    chk("reach mid-frame point", int'(found), 1);
    chk("mid-frame hcount", int'(hc_p), 5);
    chk("mid-frame vcount", int'(vc_p), 3);

    cyc(1'b0);
    chk("mid reset hcount", int'(hc_p), 0);
    chk("mid reset vcount", int'(vc_p), 0);
    chk("mid reset p.hsync", int'(hs_p), 0);
    chk("mid reset p.vsync", int'(vs_p), 0);
    chk("mid reset n.hsync", int'(hs_n), 1);
    chk("mid reset n.vsync", int'(vs_n), 1);
    chk("mid reset hblnk", int'(hb_p), 0);
    chk("mid reset vblnk", int'(vb_p), 0);
    chk("mid reset frame_start", int'(fs_p), 0);

    for (int c = 1; c <= 3; c++) begin
      cyc(1'b1);
      chk("restart hcount", int'(hc_p), c);
      chk("restart vcount", int'(vc_p), 0);
      chk("restart p.hsync", int'(hs_p), 0);
      chk("restart n.vsync", int'(vs_n), 1);
    end

    @(negedge pclk);
    @(negedge pclk);
    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates the raster timing that feeds the menu/control pipeline: hcount, vcount, hsync, vsync, hblnk and vblnk, all on pclk.
- Outputs connect directly to the timing inputs of the menu stage (vcount_in, hcount_in, vsync_in, vblnk_in, hsync_in, hblnk_in).
- Also emits a one-cycle frame_start pulse for frame-rate logic such as ball/paddle update ticks.
- Defaults give 800x600 @ 60 Hz (40 MHz pclk).

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_SYNC_START, 840, first hcount with hsync asserted
- H_SYNC_END, 968, first hcount after hsync
- H_TOTAL, 1056, pixels per line (hcount wraps at H_TOTAL-1)
- V_ACTIVE, 600, visible lines per frame
- V_SYNC_START, 601, first vcount with vsync asserted
- V_SYNC_END, 605, first vcount after vsync
- V_TOTAL, 628, lines per frame (vcount wraps at V_TOTAL-1)
- HS_POL, 1, active level of hsync
- VS_POL, 1, active level of vsync

Ports:
- pclk  in  1  pixel clock
- rst  in  1  synchronous reset, active-low
- hcount  out  11  current pixel column, 0..H_TOTAL-1
- vcount  out  11  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync at HS_POL level
- vsync  out  1  vertical sync at VS_POL level
- hblnk  out  1  high when hcount >= H_ACTIVE
- vblnk  out  1  high when vcount >= V_ACTIVE
- frame_start  out  1  one-cycle pulse coinciding with hcount==0, vcount==0

Behaviour:
- Single clock domain. Every output is a register; there are no combinational paths to outputs.
- Reset: rst is sampled low on a pclk edge. That edge sets hcount=0, vcount=0, hblnk=0, vblnk=0, hsync=~HS_POL, vsync=~VS_POL, frame_start=0.
- Reset mid-frame: same values on the next edge, regardless of counter state.
- First cycle after release: the first edge with rst high advances hcount to 1. frame_start is not asserted for the reset-state pixel (0,0); the first pulse is at the next frame's (0,0).
- Horizontal counter: hcount increments every cycle. At hcount==H_TOTAL-1 the next value is 0.
- Vertical counter: vcount increments only on the cycle where hcount wraps. At vcount==V_TOTAL-1 with hcount wrapping, vcount goes to 0.
- Alignment: hsync, vsync, hblnk, vblnk and frame_start are computed from the next-state counter values and registered. They are therefore cycle-aligned with the hcount/vcount they describe, with zero skew between counts and flags.
- hblnk = (hcount >= H_ACTIVE).
- vblnk = (vcount >= V_ACTIVE).
- hsync active for H_SYNC_START <= hcount < H_SYNC_END.
- vsync active for V_SYNC_START <= vcount < V_SYNC_END. vsync changes level only at hcount==0 of the boundary line.
- frame_start is high exactly once per H_TOTAL*V_TOTAL cycles.
- Width rules: counters are 11 bits, comparisons unsigned. The parameters must satisfy H_ACTIVE < H_SYNC_START < H_SYNC_END <= H_TOTAL <= 2048, and the same ordering for the V set. An elaboration-time check flags any violation.
- Counters never take values >= H_TOTAL / V_TOTAL, even with reset released at any point.

Decomposition:
- Shared package vga_pkg: default timing constants for 800x600 (the H_*/V_* values above) and the counter width COUNT_W=11. The menu, game and draw stages reuse it.
- Natural sub-module: vga_axis_counter, instantiated twice (horizontal, vertical). Inputs: clk, rst, inc_en. Parameters: ACTIVE, SYNC_START, SYNC_END, TOTAL, POL. Outputs: count, sync, blnk, wrap.
  - Horizontal instance: inc_en = 1.
  - Vertical instance: inc_en = horizontal wrap.
  - frame_start = both next-state counts zero.

Test Plan:
- Reset: hold rst low 5 cycles from arbitrary state → hcount=0, vcount=0, hsync=0, vsync=0, hblnk=0, vblnk=0, frame_start=0. After release, hcount reads 1,2,3 on successive edges.
- Line timing: run one line → hblnk rises at hcount=800, hsync high for hcount 840..967 (128 cycles), hcount 1055→0, and vcount increments on that same edge.
- Frame timing: run one full frame → vblnk rises at vcount=600, vsync high for vcount 601..604 (4 lines × 1056 = 4224 cycles), vcount 627→0 with hcount 1055→0.
- frame_start: run 3 frames → pulses spaced exactly 663168 cycles apart, each coinciding with hcount=0, vcount=0, single-cycle width.
- Mid-frame reset: assert rst at hcount=500, vcount=300 for 1 cycle → next edge all outputs at reset values, then counting restarts from 1 with no glitch on hsync/vsync.
- Polarity: instantiate HS_POL=0, VS_POL=0 → hsync/vsync idle high after reset and go low for 840..967 / 601..604; counts unchanged from the positive-polarity run.
